// File: rtl/board_io.sv
// board_io: DE0 board front end. Synchronises and debounces the raw
// switch/button inputs, produces rise/fall pulses, and generates a
// run-time selectable cpu clock-enable (run / tick / step / halt) plus a
// count of enabled cycles. Everything runs on the single board clock.
module board_io #(
    parameter int N_CH        = 9,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 500000,
    parameter int TICK_DIV    = 5000000,
    parameter int STEP_CH     = 8
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic [N_CH-1:0] raw_in,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            cpu_en,
    output logic [15:0]     step_count
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_TICK = 2'd1,
        MODE_STEP = 2'd2,
        MODE_HALT = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_s;

    // Shift raw inputs through the synchroniser chain.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    logic [1:0] mode_meta_q;
    mode_e      mode_q;

    // Two-flop synchroniser for the mode switches; reset parks in halt.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            mode_meta_q <= 2'd3;
            mode_q      <= MODE_HALT;
        end else begin
            mode_meta_q <= mode;
            mode_q      <= mode_e'(mode_meta_q);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce
    // ------------------------------------------------------------------
    logic [N_CH-1:0] db_lvl;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_db
            logic [CW-1:0] cnt_q, cnt_d;
            logic          lvl_q, lvl_d;

            // Accept a new level only after DB_CYCLES consecutive disagreeing samples.
            always_comb begin
                cnt_d = cnt_q;
                lvl_d = lvl_q;
                if (sync_s[gi] == lvl_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    lvl_d = sync_s[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Debounce counter and accepted level registers.
            always_ff @(posedge clk or negedge nReset) begin
                if (!nReset) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign db_lvl[gi] = lvl_q;
        end
    endgenerate

    logic [N_CH-1:0] db_prev_q;

    // Previous debounced level, used to form the edge pulses.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            db_prev_q <= '0;
        end else begin
            db_prev_q <= db_lvl;
        end
    end

    assign db_out = db_lvl;
    assign rise   = db_lvl & ~db_prev_q;
    assign fall   = ~db_lvl & db_prev_q;

    // ------------------------------------------------------------------
    // Tick divider, cpu enable and enabled-cycle counter
    // ------------------------------------------------------------------
    // div_run_q delays the divider start by one cycle so the first tick
    // lands TICK_DIV cycles after the mode change first reaches cpu_en.
    logic          div_run_q;
    logic [DW-1:0] div_q, div_d;
    logic          cpu_en_q, cpu_en_d;
    logic [15:0]   step_count_q;

    // Divider next state and mode-selected enable.
    always_comb begin
        div_d    = '0;
        cpu_en_d = 1'b0;
        if (mode_q == MODE_TICK && div_run_q) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        end
        unique case (mode_q)
            MODE_RUN:  cpu_en_d = 1'b1;
            MODE_TICK: cpu_en_d = (div_q == DIV_LAST);
            MODE_STEP: cpu_en_d = rise[STEP_CH];
            MODE_HALT: cpu_en_d = 1'b0;
            default:   cpu_en_d = 1'b0;
        endcase
    end

    // Divider, enable and step counter registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            div_run_q    <= 1'b0;
            div_q        <= '0;
            cpu_en_q     <= 1'b0;
            step_count_q <= 16'd0;
        end else begin
            div_run_q <= (mode_q == MODE_TICK);
            div_q     <= div_d;
            cpu_en_q  <= cpu_en_d;
            if (cpu_en_q) begin
                step_count_q <= step_count_q + 16'd1;
            end
        end
    end

    assign cpu_en     = cpu_en_q;
    assign step_count = step_count_q;

endmodule

// File: doc/board_io.md
Name: board_io

Overview:
- Parametrised board front end between the DE0 switches/buttons and the cpu, running entirely on the 50 MHz board clock.
- Synchronises and debounces N_CH raw inputs, producing clean levels plus one-cycle rise/fall pulses.
- Generates a cpu clock-enable whose mode is selectable at run time: full speed, divided tick (~10 Hz), single-step on the debounced step button, or halt.
- Replaces the fixed slow-clock divider and single-channel debouncer with one block that needs no derived clock.

Parameters:
N_CH, 9, number of debounced input channels
SYNC_STAGES, 2, flops in each input synchroniser chain (>=2)
DB_CYCLES, 500000, consecutive stable cycles required to accept a new level (>=1; 10 ms at 50 MHz)
TICK_DIV, 5000000, clock cycles per enable in tick mode (>=2; 10 Hz at 50 MHz)
STEP_CH, 8, channel whose debounced rising edge single-steps the cpu (<N_CH)

Ports:
clk  input  1  board clock, all state on rising edge
nReset  input  1  asynchronous active-low reset
raw_in  input  N_CH  raw switch/button levels, asynchronous to clk
mode  input  2  enable mode (raw switches): 0 run, 1 tick, 2 step, 3 halt
db_out  output  N_CH  debounced levels
rise  output  N_CH  one-cycle pulse when db_out bit goes 0->1
fall  output  N_CH  one-cycle pulse when db_out bit goes 1->0
cpu_en  output  1  registered clock-enable for the cpu
step_count  output  16  number of cycles with cpu_en=1, wraps 0xFFFF->0

Behaviour:
- Reset (nReset low, asynchronous, effective immediately mid-operation):
  - all sync flops, db_out, db_prev, debounce counters, divider and step_count = 0
  - mode_q = 3 (halt), cpu_en = 0
  - rise/fall are therefore 0 during reset
- Synchroniser: each raw_in bit passes through SYNC_STAGES flops -> sync[i]. mode passes through its own 2-flop chain -> mode_q.
- Debounce, per channel, each cycle:
  - sync[i]==db_out[i]: cnt[i] <= 0
  - sync[i]!=db_out[i] and cnt[i]==DB_CYCLES-1: db_out[i] <= sync[i], cnt[i] <= 0
  - otherwise: cnt[i] <= cnt[i]+1
  - cnt width = clog2(DB_CYCLES), minimum 1.
  - A raw edge held stable appears on db_out exactly SYNC_STAGES+DB_CYCLES rising edges later.
  - Any reversion before acceptance restarts the count; glitches shorter than DB_CYCLES never propagate.
- Edge pulses:
  - db_prev <= db_out each cycle.
  - rise = db_out & ~db_prev; fall = ~db_out & db_prev.
  - Exactly one cycle wide, never both set on a bit, first asserted in the cycle db_out changes.
- Divider: div counts 0..TICK_DIV-1 and wraps only while mode_q==1; held at 0 in other modes. On entering tick mode, the first tick occurs TICK_DIV cycles later.
- cpu_en, registered, from mode_q:
  - 0: 1
  - 1: (div==TICK_DIV-1)
  - 2: rise[STEP_CH], i.e. exactly one cpu_en cycle per accepted press, one cycle after rise
  - 3: 0
- Mode-change latency: a mode change on the pins affects cpu_en 3 cycles later (2 sync + 1 register). No partial or duplicated pulses on a change.
- step_count: increments on every edge where cpu_en==1, modulo 2^16.
- In step mode, STEP_CH still appears normally on db_out/rise/fall. The cpu inport uses db_out[STEP_CH] as readyIn in other modes.

Test Plan (N_CH=4, SYNC_STAGES=2, DB_CYCLES=4, TICK_DIV=5, STEP_CH=3):
- Reset and sync: assert nReset=0 with raw_in=4'hF, mode=0 -> all outputs 0 and cpu_en=0. Release reset -> cpu_en=1 exactly 3 cycles later, step_count counts 1,2,3...; db_out=4'hF after 6 cycles with rise=4'hF for one cycle only.
- Clean edge: raw_in[0] 0->1 held -> db_out[0]=1 exactly 6 edges later; rise[0] high 1 cycle; fall never. Then 1->0 held -> fall[0] 1 cycle after 6 edges.
- Bounce rejection: raw_in[1] high 3 cycles, low 1, high 3, low -> db_out[1] stays 0, rise[1] never asserts. Holding high >=4 stable sync cycles -> accepted.
- Tick mode: mode=1 from reset-released idle -> cpu_en pulses 1 cycle every 5 cycles, first pulse 3+5 cycles after the pin change. step_count +1 per pulse; 20 pulses -> step_count=20.
- Step mode: mode=2, three debounced presses of raw_in[3] -> exactly three cpu_en pulses, each one cycle after rise[3]. Holding the button produces no further pulses; mode=3 -> cpu_en=0 after 3 cycles.
- Mid-operation reset and wrap:
  - nReset low for half a cycle mid-debounce and mid-tick -> outputs clear immediately; a partial count is not resumed (needs a full 6 cycles after release).
  - Preload step_count to 0xFFFF via mode 0 run, one more enable -> 0x0000.
